// File: rtl/ukp_report_scanner_if.sv
// Bundles the ukp report-register bus and the key-FIFO consumer stream.
interface ukp_report_scanner_if;
  logic [3:0] kbd_adr;
  logic [7:0] kbd_data;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_usage;
  logic [7:0] key_mods;
  logic       fifo_overflow;
  logic       overflow_clr;
  logic       scan_busy;

  modport master (
    output kbd_adr, key_valid, key_usage, key_mods, fifo_overflow, scan_busy,
    input  kbd_data, key_ready, overflow_clr
  );

  modport slave (
    input  kbd_adr, key_valid, key_usage, key_mods, fifo_overflow, scan_busy,
    output kbd_data, key_ready, overflow_clr
  );
endinterface

// File: rtl/ukp_report_scanner.sv
// Scans the ukp keyboard report after each completed USB report, diffs the six
// boot keycodes against the previous report and queues newly pressed keys.
//
//   state  | meaning
//   IDLE   | waiting for record_n rising edge
//   READ   | stepping kbd_adr 0..7, capturing one byte per RD_LAT+1 cycles
//   EMIT   | one cycle per keycode slot 2..7, pushing new keys
//   COMMIT | copy current keycodes into the previous-report table
module ukp_report_scanner #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk25,
  input  logic                 rst,
  input  logic                 record_n,
  ukp_report_scanner_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EMIT, S_COMMIT} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic          rise_evt, fall_evt;
  logic [2:0]    idx_q, slot_q, slot_idx;
  logic [1:0]    lat_q;
  logic [7:0]    cur_q [8];
  logic [7:0]    prev_q [6];
  logic [7:0]    slot_byte;
  logic          rollover, match, push_req;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    usage_q, mods_q, usage_d, mods_d;
  logic          ovf_q, full, pop, push, ovf_set;

  assign rise_evt  = sync2_q & ~sync3_q;
  assign fall_evt  = ~sync2_q & sync3_q;
  assign slot_idx  = slot_q + 3'd2;
  assign slot_byte = cur_q[slot_idx];

  // record_n synchroniser (idle-high) plus one extra flop for edge detection
  always_ff @(posedge clk25) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= record_n;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // rollover marker and previous-report match for the current emit slot
  always_comb begin
    rollover = (bus.kbd_data == 8'h01);
    for (int i = 2; i < 7; i++) begin
      if (cur_q[i] == 8'h01) rollover = 1'b1;
    end
    match = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (prev_q[j] == slot_byte) match = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk25) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; a falling record_n aborts READ/EMIT without commit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rise_evt) state_d = S_READ;
      S_READ: begin
        if (fall_evt) state_d = S_IDLE;
        else if (lat_q == 2'd0 && idx_q == 3'd7) state_d = rollover ? S_IDLE : S_EMIT;
      end
      S_EMIT: begin
        if (fall_evt) state_d = S_IDLE;
        else if (slot_q == 3'd5) state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    push_req      = (state_q == S_EMIT) && !fall_evt && (slot_byte != 8'h00) && !match;
    bus.scan_busy = (state_q != S_IDLE);
    bus.kbd_adr   = (state_q == S_READ) ? {1'b0, idx_q} : 4'd0;
  end

  // scan datapath: byte index, latency down-counter, emit slot, report tables
  always_ff @(posedge clk25) begin
    if (rst) begin
      idx_q  <= '0;
      lat_q  <= '0;
      slot_q <= '0;
      for (int i = 0; i < 8; i++) cur_q[i] <= '0;
      for (int i = 0; i < 6; i++) prev_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise_evt) begin
            idx_q  <= '0;
            lat_q  <= 2'(RD_LAT);
            slot_q <= '0;
          end
        end
        S_READ: begin
          if (lat_q == 2'd0) begin
            cur_q[idx_q] <= bus.kbd_data;
            idx_q        <= idx_q + 3'd1;
            lat_q        <= 2'(RD_LAT);
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        S_EMIT:   slot_q <= slot_q + 3'd1;
        S_COMMIT: for (int i = 0; i < 6; i++) prev_q[i] <= cur_q[i+2];
        default: ;
      endcase
    end
  end

  // FIFO control; the head is registered so outputs hold the last popped entry when empty
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = (count_q != '0) && bus.key_ready;
    push     = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    count_d  = count_q + CW'(push) - CW'(pop);
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    usage_d  = usage_q;
    mods_d   = mods_q;
    if (count_d != '0) begin
      if (count_q == '0 || (count_q == CW'(1) && pop)) begin
        usage_d = slot_byte;
        mods_d  = cur_q[0];
      end else begin
        {usage_d, mods_d} = mem_q[rd_ptr_d];
      end
    end
  end

  // FIFO pointers, occupancy, head register and sticky overflow
  always_ff @(posedge clk25) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      usage_q  <= '0;
      mods_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      usage_q  <= usage_d;
      mods_q   <= mods_d;
      if (ovf_set)               ovf_q <= 1'b1;
      else if (bus.overflow_clr) ovf_q <= 1'b0;
    end
  end

  // FIFO storage: {usage, mods}
  always_ff @(posedge clk25) begin
    if (!rst && push) mem_q[wr_ptr_q] <= {slot_byte, cur_q[0]};
  end

  assign bus.key_valid     = (count_q != '0);
  assign bus.key_usage     = usage_q;
  assign bus.key_mods      = mods_q;
  assign bus.fifo_overflow = ovf_q;
endmodule
